// File: rtl/amp_seq_ctrl.sv
// Power-up, configuration and fault-recovery sequencer for one class-D amplifier.
// All amplifier-facing outputs are registered from the next state.
module amp_seq_ctrl #(
    parameter int unsigned ENABLE_WAIT_CYC = 1000,
    parameter int unsigned CFG_TIMEOUT_CYC = 4000,
    parameter int unsigned SETTLE_CYC      = 500,
    parameter int unsigned LOCK_STABLE_CYC = 256,
    parameter int unsigned HOLDOFF_CYC     = 2000,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned TIMER_W         = 16
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       audio_locked_in,
    input  logic       nerror_in,
    input  logic       config_done_in,
    input  logic       clear_in,
    output logic       nenable_out,
    output logic       nmute_out,
    output logic       send_config_out,
    output logic       fault_out,
    output logic [2:0] state_out,
    output logic [3:0] retry_cnt_out
);

    localparam longint unsigned TIMER_MAX = (64'd1 << TIMER_W) - 64'd1;

    if (ENABLE_WAIT_CYC < 1 || longint'(ENABLE_WAIT_CYC) > TIMER_MAX ||
        CFG_TIMEOUT_CYC < 1 || longint'(CFG_TIMEOUT_CYC) > TIMER_MAX ||
        SETTLE_CYC < 1      || longint'(SETTLE_CYC) > TIMER_MAX      ||
        LOCK_STABLE_CYC < 1 || longint'(LOCK_STABLE_CYC) > TIMER_MAX ||
        HOLDOFF_CYC < 1     || longint'(HOLDOFF_CYC) > TIMER_MAX     ||
        MAX_RETRY < 1       || MAX_RETRY > 15) begin : g_bad_params
        $error("amp_seq_ctrl: parameter out of range");
    end

    localparam logic [TIMER_W-1:0] ENABLE_LOAD = TIMER_W'(ENABLE_WAIT_CYC - 1);
    localparam logic [TIMER_W-1:0] CFG_LOAD    = TIMER_W'(CFG_TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYC - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(HOLDOFF_CYC - 1);
    localparam logic [TIMER_W-1:0] LOCK_MAX    = TIMER_W'(LOCK_STABLE_CYC);
    localparam logic [3:0]         RETRY_MAX   = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        StInit       = 3'd0,
        StEnableWait = 3'd1,
        StConfig     = 3'd2,
        StSettle     = 3'd3,
        StRun        = 3'd4,
        StFaultHold  = 3'd5,
        StLockout    = 3'd6
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_d;
    logic [TIMER_W-1:0] r_lock;
    logic [TIMER_W-1:0] w_lock_d;
    logic [3:0]         r_retry;
    logic [3:0]         w_retry_d;
    logic               w_fault;
    logic               r_nenable;
    logic               r_nmute;
    logic               r_send;
    logic               r_fault;
    logic               w_nenable_d;
    logic               w_nmute_d;
    logic               w_send_d;
    logic               w_fault_d;

    always_comb begin
        w_state_d = r_state;
        w_timer_d = (r_timer != '0) ? r_timer - TIMER_W'(1) : '0;
        w_retry_d = r_retry;
        w_fault   = 1'b0;

        case (r_state)
            StInit: begin
                w_state_d = StEnableWait;
                w_timer_d = ENABLE_LOAD;
            end
            StEnableWait: begin
                w_fault = !nerror_in;
                if (r_timer == '0) begin
                    w_state_d = StConfig;
                    w_timer_d = CFG_LOAD;
                end
            end
            StConfig: begin
                w_fault = !nerror_in;
                if (config_done_in) begin
                    w_state_d = StSettle;
                    w_timer_d = SETTLE_LOAD;
                end else if (r_timer == '0) begin
                    w_fault = 1'b1;
                end
            end
            StSettle: begin
                w_fault = !nerror_in;
                if (r_timer == '0) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_fault = !nerror_in;
            end
            StFaultHold: begin
                if (r_timer == '0 && nerror_in) begin
                    w_state_d = StInit;
                end
            end
            StLockout: begin
                if (clear_in) begin
                    w_state_d = StInit;
                    w_retry_d = '0;
                end
            end
            default: begin
                w_state_d = StInit;
            end
        endcase

        // A fault overrides any transition chosen above.
        if (w_fault) begin
            if (r_retry < RETRY_MAX) begin
                w_retry_d = r_retry + 4'd1;
                w_state_d = StFaultHold;
                w_timer_d = HOLD_LOAD;
            end else begin
                w_state_d = StLockout;
            end
        end
    end

    // The lock count starts on the edge that enters RUN, so the lock seen at that edge counts.
    always_comb begin
        w_lock_d = '0;
        if (w_state_d == StRun && audio_locked_in) begin
            w_lock_d = (r_lock == LOCK_MAX) ? r_lock : r_lock + TIMER_W'(1);
        end
        w_nmute_d   = (w_state_d == StRun) && audio_locked_in && (r_lock == LOCK_MAX);
        w_nenable_d = !(w_state_d inside {StEnableWait, StConfig, StSettle, StRun});
        w_send_d    = w_state_d inside {StConfig, StSettle, StRun};
        w_fault_d   = (w_state_d == StLockout);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state   <= StInit;
            r_timer   <= '0;
            r_lock    <= '0;
            r_retry   <= '0;
            r_nenable <= 1'b1;
            r_nmute   <= 1'b0;
            r_send    <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_timer   <= w_timer_d;
            r_lock    <= w_lock_d;
            r_retry   <= w_retry_d;
            r_nenable <= w_nenable_d;
            r_nmute   <= w_nmute_d;
            r_send    <= w_send_d;
            r_fault   <= w_fault_d;
        end
    end

    assign nenable_out     = r_nenable;
    assign nmute_out       = r_nmute;
    assign send_config_out = r_send;
    assign fault_out       = r_fault;
    assign state_out       = r_state;
    assign retry_cnt_out   = r_retry;

endmodule

// File: tb/tb_amp_seq_ctrl.sv
// Scenario bench for amp_seq_ctrl: each task queues the expected output vectors
// for chosen cycles, drives stimulus and compares as those cycles arrive.
module tb_amp_seq_ctrl;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       audio_locked_in;
    logic       nerror_in;
    logic       config_done_in;
    logic       clear_in;
    logic       nenable_out;
    logic       nmute_out;
    logic       send_config_out;
    logic       fault_out;
    logic [2:0] state_out;
    logic [3:0] retry_cnt_out;

    amp_seq_ctrl #(
        .ENABLE_WAIT_CYC(8),
        .CFG_TIMEOUT_CYC(16),
        .SETTLE_CYC     (4),
        .LOCK_STABLE_CYC(3),
        .HOLDOFF_CYC    (10),
        .MAX_RETRY      (2),
        .TIMER_W        (16)
    ) u_dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .audio_locked_in(audio_locked_in),
        .nerror_in      (nerror_in),
        .config_done_in (config_done_in),
        .clear_in       (clear_in),
        .nenable_out    (nenable_out),
        .nmute_out      (nmute_out),
        .send_config_out(send_config_out),
        .fault_out      (fault_out),
        .state_out      (state_out),
        .retry_cnt_out  (retry_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    // Vector layout: {state[2:0], nenable, nmute, send_config, fault, retry[3:0]}
    typedef struct {
        int          cyc;
        logic [10:0] v;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic logic [10:0] pk(input logic [2:0] st, input logic nen, input logic nmu,
                                       input logic scfg, input logic flt, input logic [3:0] rty);
        return {st, nen, nmu, scfg, flt, rty};
    endfunction

    function automatic logic [10:0] obs();
        return {state_out, nenable_out, nmute_out, send_config_out, fault_out, retry_cnt_out};
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    // Leaves the bench in cycle 0: reset released, first non-reset edge still ahead.
    task automatic do_reset();
        reset_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        cyc      = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset_in        = 1'b1;
        audio_locked_in = 1'b1;
        nerror_in       = 1'b0;
        config_done_in  = 1'b1;
        clear_in        = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++;
        if (obs() !== pk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0)) begin
            n_err++;
            $display("FAIL reset_held got=%b exp=%b", obs(), pk(3'd0, 1, 0, 0, 0, 4'd0));
        end
        nerror_in      = 1'b1;
        config_done_in = 1'b0;
        clear_in       = 1'b0;
        reset_in       = 1'b0;
        cyc            = 0;
        q.push_back('{0, pk(3'd0, 1, 0, 0, 0, 4'd0), "reset_cycle0"});
        q.push_back('{1, pk(3'd1, 0, 0, 0, 0, 4'd0), "reset_cycle1_enable"});
        for (int c = 0; c <= 1; c++) begin
            if (c > 0) step();
            while (q.size() != 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_checks++;
                if (obs() !== e.v) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, obs(), e.v);
                end
            end
        end
    endtask

    task automatic test_nominal();
        exp_t e;
        audio_locked_in = 1'b1;
        nerror_in       = 1'b1;
        config_done_in  = 1'b0;
        do_reset();
        q.push_back('{0,  pk(3'd0, 1, 0, 0, 0, 4'd0), "nom_init"});
        q.push_back('{1,  pk(3'd1, 0, 0, 0, 0, 4'd0), "nom_enable_fall"});
        q.push_back('{8,  pk(3'd1, 0, 0, 0, 0, 4'd0), "nom_enable_last"});
        q.push_back('{9,  pk(3'd2, 0, 0, 1, 0, 4'd0), "nom_send_config"});
        q.push_back('{14, pk(3'd2, 0, 0, 1, 0, 4'd0), "nom_config_last"});
        q.push_back('{15, pk(3'd3, 0, 0, 1, 0, 4'd0), "nom_settle"});
        q.push_back('{18, pk(3'd3, 0, 0, 1, 0, 4'd0), "nom_settle_last"});
        q.push_back('{19, pk(3'd4, 0, 0, 1, 0, 4'd0), "nom_run_muted"});
        q.push_back('{21, pk(3'd4, 0, 0, 1, 0, 4'd0), "nom_run_still_muted"});
        q.push_back('{22, pk(3'd4, 0, 1, 1, 0, 4'd0), "nom_unmute"});
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) step();
            if (cyc == 14) config_done_in = 1'b1;
            while (q.size() != 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_checks++;
                if (obs() !== e.v) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, obs(), e.v);
                end
            end
        end
    endtask

    // Continues from the end of test_nominal (RUN, unmuted, cycle 22).
    task automatic test_lock_drop();
        exp_t e;
        q.push_back('{24, pk(3'd4, 0, 1, 1, 0, 4'd0), "drop_before"});
        q.push_back('{25, pk(3'd4, 0, 0, 1, 0, 4'd0), "drop_mute_first"});
        q.push_back('{28, pk(3'd4, 0, 0, 1, 0, 4'd0), "drop_mute_fourth"});
        q.push_back('{29, pk(3'd4, 0, 1, 1, 0, 4'd0), "drop_unmute"});
        for (int c = 23; c <= 29; c++) begin
            step();
            if (cyc == 24) audio_locked_in = 1'b0;
            if (cyc == 25) audio_locked_in = 1'b1;
            while (q.size() != 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_checks++;
                if (obs() !== e.v) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, obs(), e.v);
                end
            end
        end
    endtask

    task automatic test_cfg_timeout();
        exp_t e;
        audio_locked_in = 1'b1;
        nerror_in       = 1'b1;
        config_done_in  = 1'b0;
        do_reset();
        q.push_back('{9,  pk(3'd2, 0, 0, 1, 0, 4'd0), "tmo_config"});
        q.push_back('{24, pk(3'd2, 0, 0, 1, 0, 4'd0), "tmo_config_last"});
        q.push_back('{25, pk(3'd5, 1, 0, 0, 0, 4'd1), "tmo_fault_hold"});
        q.push_back('{34, pk(3'd5, 1, 0, 0, 0, 4'd1), "tmo_hold_last"});
        q.push_back('{35, pk(3'd0, 1, 0, 0, 0, 4'd1), "tmo_init"});
        q.push_back('{36, pk(3'd1, 0, 0, 0, 0, 4'd1), "tmo_reenable"});
        for (int c = 0; c <= 36; c++) begin
            if (c > 0) step();
            while (q.size() != 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_checks++;
                if (obs() !== e.v) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, obs(), e.v);
                end
            end
        end
    endtask

    task automatic test_lockout();
        exp_t e;
        audio_locked_in = 1'b1;
        nerror_in       = 1'b1;
        config_done_in  = 1'b1;
        clear_in        = 1'b0;
        do_reset();
        q.push_back('{14, pk(3'd4, 0, 0, 1, 0, 4'd0), "lo_run1"});
        q.push_back('{16, pk(3'd5, 1, 0, 0, 0, 4'd1), "lo_fault1"});
        q.push_back('{40, pk(3'd4, 0, 0, 1, 0, 4'd1), "lo_run2_keeps_retry"});
        q.push_back('{42, pk(3'd5, 1, 0, 0, 0, 4'd2), "lo_fault2"});
        q.push_back('{66, pk(3'd4, 0, 0, 1, 0, 4'd2), "lo_run3"});
        q.push_back('{68, pk(3'd6, 1, 0, 0, 1, 4'd2), "lo_lockout"});
        q.push_back('{73, pk(3'd6, 1, 0, 0, 1, 4'd2), "lo_lockout_ignores"});
        q.push_back('{74, pk(3'd0, 1, 0, 0, 0, 4'd0), "lo_clear_init"});
        q.push_back('{75, pk(3'd1, 0, 0, 0, 0, 4'd0), "lo_after_clear"});
        for (int c = 0; c <= 75; c++) begin
            if (c > 0) step();
            if (cyc == 15 || cyc == 41 || cyc == 67) nerror_in = 1'b0;
            if (cyc == 16 || cyc == 42 || cyc == 68) nerror_in = 1'b1;
            if (cyc == 70) begin
                nerror_in       = 1'b0;
                audio_locked_in = 1'b0;
            end
            if (cyc == 73) begin
                clear_in        = 1'b1;
                nerror_in       = 1'b1;
                audio_locked_in = 1'b1;
            end
            if (cyc == 74) clear_in = 1'b0;
            while (q.size() != 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_checks++;
                if (obs() !== e.v) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, obs(), e.v);
                end
            end
        end
    endtask

    task automatic test_sticky();
        exp_t e;
        audio_locked_in = 1'b1;
        nerror_in       = 1'b1;
        config_done_in  = 1'b1;
        do_reset();
        q.push_back('{16, pk(3'd5, 1, 0, 0, 0, 4'd1), "sticky_enter"});
        q.push_back('{26, pk(3'd5, 1, 0, 0, 0, 4'd1), "sticky_timer_done"});
        q.push_back('{41, pk(3'd5, 1, 0, 0, 0, 4'd1), "sticky_still_hold"});
        q.push_back('{42, pk(3'd0, 1, 0, 0, 0, 4'd1), "sticky_release"});
        q.push_back('{43, pk(3'd1, 0, 0, 0, 0, 4'd1), "sticky_reenable"});
        for (int c = 0; c <= 43; c++) begin
            if (c > 0) step();
            if (cyc == 15) nerror_in = 1'b0;
            if (cyc == 41) nerror_in = 1'b1;
            while (q.size() != 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_checks++;
                if (obs() !== e.v) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, obs(), e.v);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        audio_locked_in = 1'b1;
        nerror_in       = 1'b1;
        config_done_in  = 1'b0;
        do_reset();
        q.push_back('{12, pk(3'd2, 0, 0, 1, 0, 4'd0), "rmid_config"});
        q.push_back('{13, pk(3'd0, 1, 0, 0, 0, 4'd0), "rmid_reset_applied"});
        q.push_back('{14, pk(3'd0, 1, 0, 0, 0, 4'd0), "rmid_reset_held"});
        for (int c = 0; c <= 14; c++) begin
            if (c > 0) step();
            if (cyc == 12) begin
                config_done_in = 1'b1;
                nerror_in      = 1'b0;
                reset_in       = 1'b1;
            end
            while (q.size() != 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_checks++;
                if (obs() !== e.v) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, obs(), e.v);
                end
            end
        end
        reset_in       = 1'b0;
        nerror_in      = 1'b1;
        config_done_in = 1'b0;
    endtask

    initial begin
        reset_in        = 1'b1;
        audio_locked_in = 1'b0;
        nerror_in       = 1'b1;
        config_done_in  = 1'b0;
        clear_in        = 1'b0;
        cyc             = 0;
        test_reset();
        test_nominal();
        test_lock_drop();
        test_cfg_timeout();
        test_lockout();
        test_sticky();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
